// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register writeback path.
// Optional forwarding data is enabled with WB_BYPASS_EN.
package reg_writeback_pkg;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  localparam logic [RW-1:0] ZERO_REG = 5'd0;
  localparam logic [RW-1:0] LINK_REG = 5'd31;

  localparam logic [1:0] SEL_RT   = 2'b00;
  localparam logic [1:0] SEL_RD   = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE
  } wb_state_t;

  typedef struct packed {
    logic [RW-1:0]   dest;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// Writeback FIFO: storage, pointers, count and per-entry address compare.
// Match vectors are ordered by age (bit 0 = oldest entry).
module wb_queue
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        push_entry,
  output wb_entry_t        head,
  output logic             empty,
  output logic             full,
  input  logic [RW-1:0]    rs,
  input  logic [RW-1:0]    rt,
  output logic [DEPTH-1:0] rs_match,
  output logic [DEPTH-1:0] rt_match
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0][XLEN-1:0] age_data
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [AW-1:0] idx;
    logic          live;
    assign idx         = rd_ptr + AW'(g);
    assign live        = (CW'(g) < count);
    assign rs_match[g] = live && (mem[idx].dest == rs);
    assign rt_match[g] = live && (mem[idx].dest == rt);
`ifdef WB_BYPASS_EN
    assign age_data[g] = mem[idx].data;
`endif
  end
endmodule

// File: rtl/reg_writeback.sv
// Writeback queue drain with setup/pulse strobe and hazard lookup.
// Define WB_BYPASS_EN to add forwarding data outputs.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_sel,
  input  logic [1:0]      in_src,
  input  logic [RW-1:0]   in_rt,
  input  logic [RW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_mem,
  input  logic [XLEN-1:0] in_pc4,
  output logic            RegWre,
  output logic [RW-1:0]   WriteReg,
  output logic [XLEN-1:0] WriteData,
  input  logic [RW-1:0]   rs,
  input  logic [RW-1:0]   rt,
  output logic            rs_pending,
  output logic            rt_pending
`ifdef WB_BYPASS_EN
  ,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data
`endif
);
  wb_state_t        state, next_state;
  wb_entry_t        req, head;
  logic             empty, full, push, pop, wre_next;
  logic             inflight, rs_live, rt_live;
  logic [DEPTH-1:0] rs_match, rt_match;
`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0][XLEN-1:0] age_data;
`endif

  always_comb begin
    req = '0;
    unique case (in_sel)
      SEL_RT:   req.dest = in_rt;
      SEL_RD:   req.dest = in_rd;
      SEL_LINK: req.dest = LINK_REG;
      default:  req.dest = ZERO_REG;
    endcase
    unique case (in_src)
      SRC_ALU: req.data = in_alu;
      SRC_MEM: req.data = in_mem;
      SRC_PC4: req.data = in_pc4;
      default: req.data = '0;
    endcase
  end

  assign in_ready = !full;
  assign push     = in_valid && !full && !Reset;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (CLK),
    .rst        (Reset),
    .push       (push),
    .pop        (pop),
    .push_entry (req),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .rs         (rs),
    .rt         (rt),
    .rs_match   (rs_match),
    .rt_match   (rt_match)
`ifdef WB_BYPASS_EN
    ,
    .age_data   (age_data)
`endif
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    wre_next   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        next_state = S_PULSE;
        wre_next   = (WriteReg != ZERO_REG);
      end
      S_PULSE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = S_SETUP;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Address/data only move on a pop, so they hold across the strobe.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWre <= wre_next;
      if (pop) begin
        WriteReg  <= head.dest;
        WriteData <= head.data;
      end
    end
  end

  assign inflight   = (state != S_IDLE);
  assign rs_live    = inflight && (WriteReg == rs);
  assign rt_live    = inflight && (WriteReg == rt);
  assign rs_pending = (rs != ZERO_REG) && (rs_live || |rs_match);
  assign rt_pending = (rt != ZERO_REG) && (rt_live || |rt_match);

`ifdef WB_BYPASS_EN
  // Younger queue entries override older ones and the in-flight write.
  always_comb begin
    fwd1_data = rs_live ? WriteData : '0;
    fwd2_data = rt_live ? WriteData : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rs_match[i]) fwd1_data = age_data[i];
      if (rt_match[i]) fwd2_data = age_data[i];
    end
    if (rs == ZERO_REG) fwd1_data = '0;
    if (rt == ZERO_REG) fwd2_data = '0;
  end
`endif
endmodule
